// File: rtl/mul_sched.sv
// Two-requester scheduler sharing one signed 32x32->64 multiplier.
// Round-robin grant, operands held WAIT_CYC cycles, product returned on a valid/ready response port.
module mul_sched #(
    parameter int WAIT_CYC = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [63:0] rsp_product,
    output logic        busy
);

    // Request and response ports: a transfer happens in a cycle where valid and
    // ready are both high; requesters hold valid and operands until ready, and
    // rsp_valid/rsp_id/rsp_product stay stable until rsp_ready.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               last_grant;
    logic               grant;
    logic               accept;
    logic [3:0]         cnt;
    logic signed [31:0] op_a;
    logic signed [31:0] op_b;
    logic               op_id;
    logic signed [63:0] mul_out;

    // The only multiplier; fed exclusively from the operand registers.
    assign mul_out = op_a * op_b;

    always_comb begin
        state_next = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        // A lone requester wins; on a tie the one not granted last wins.
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else begin
            grant = req1_valid;
        end
        case (state)
            IDLE: begin
                if (!rst) begin
                    req0_ready = req0_valid && !grant;
                    req1_ready = req1_valid && grant;
                    if (req0_valid || req1_valid) begin
                        state_next = EXEC;
                    end
                end
            end
            EXEC: begin
                if (cnt == 4'd1) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept    = req0_ready || req1_ready;
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant  <= 1'b1;
            cnt         <= 4'd0;
            op_a        <= '0;
            op_b        <= '0;
            op_id       <= 1'b0;
            rsp_product <= '0;
            rsp_id      <= 1'b0;
        end else begin
            if (accept) begin
                op_a       <= grant ? req1_a : req0_a;
                op_b       <= grant ? req1_b : req0_b;
                op_id      <= grant;
                last_grant <= grant;
                cnt        <= 4'(WAIT_CYC);
            end else if (state == EXEC) begin
                cnt <= cnt - 4'd1;
            end
            // Last EXEC cycle: capture the product; it then holds until the next capture.
            if (state == EXEC && cnt == 4'd1) begin
                rsp_product <= mul_out;
                rsp_id      <= op_id;
            end
        end
    end

endmodule

// File: tb/tb_mul_sched.sv
// Bench for mul_sched: two instances (WAIT_CYC 1 and 3) driven by requester tasks,
// checked every cycle against a transaction-level model with an expected queue.
module tb_mul_sched;

    logic        clk;
    logic        rst;
    logic        req0_valid [2];
    logic        req0_ready [2];
    logic [31:0] req0_a     [2];
    logic [31:0] req0_b     [2];
    logic        req1_valid [2];
    logic        req1_ready [2];
    logic [31:0] req1_a     [2];
    logic [31:0] req1_b     [2];
    logic        rsp_valid  [2];
    logic        rsp_ready  [2];
    logic        rsp_id     [2];
    logic [63:0] rsp_product[2];
    logic        busy       [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mul_sched #(.WAIT_CYC((g == 0) ? 1 : 3)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .req0_valid (req0_valid[g]),
            .req0_ready (req0_ready[g]),
            .req0_a     (req0_a[g]),
            .req0_b     (req0_b[g]),
            .req1_valid (req1_valid[g]),
            .req1_ready (req1_ready[g]),
            .req1_a     (req1_a[g]),
            .req1_b     (req1_b[g]),
            .rsp_valid  (rsp_valid[g]),
            .rsp_ready  (rsp_ready[g]),
            .rsp_id     (rsp_id[g]),
            .rsp_product(rsp_product[g]),
            .busy       (busy[g])
        );
    end

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int          n_checks    = 0;
    int          n_fail      = 0;
    int          timeout_cnt = 0;
    logic        end_req     = 1'b0;
    int          rr_mode [2] = '{0, 0};
    logic [64:0] exp_q0[$];
    logic [64:0] exp_q1[$];
    logic        m_free   [2];
    logic        m_last   [2];
    int          acc_cyc  [2];
    logic [63:0] last_prod[2];
    logic        last_id  [2];

    logic [31:0] ca[5] = '{32'h8000_0000, 32'd0, 32'hffff_ffff, 32'd3, 32'h7fff_ffff};
    logic [31:0] cb[5] = '{32'h8000_0000, 32'hffff_fff9, 32'd10, 32'hffff_fffc, 32'hffff_ffff};

    function automatic int wc(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p;
    endfunction

    function automatic logic [31:0] rnd_op();
        if ($urandom_range(0, 3) == 0) return ca[$urandom_range(0, 4)];
        return $urandom();
    endfunction

    task automatic check(input int i, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (inst %0d, cycle %0d): got %0h expected %0h", name, i, cyc, act, exp);
        end
    endtask

    // One cycle of the reference model for instance i, sampled mid-cycle.
    task automatic mon_step(input int i);
        logic        ev;
        logic        hs;
        logic        win;
        logic        er0;
        logic        er1;
        logic [64:0] e;
        ev = !m_free[i] && (cyc >= acc_cyc[i] + wc(i) + 1);
        if (rst) begin
            check(i, "rst_ready0", 64'(req0_ready[i]), 64'd0);
            check(i, "rst_ready1", 64'(req1_ready[i]), 64'd0);
            check(i, "rst_rsp_valid", 64'(rsp_valid[i]), 64'(ev));
            m_free[i]    = 1'b1;
            m_last[i]    = 1'b1;
            last_prod[i] = '0;
            last_id[i]   = 1'b0;
            if (i == 0) exp_q0.delete(); else exp_q1.delete();
            return;
        end
        check(i, "busy", 64'(busy[i]), 64'(!m_free[i]));
        check(i, "rsp_valid", 64'(rsp_valid[i]), 64'(ev));
        hs = 1'b0;
        if (m_free[i]) begin
            check(i, "hold_product", rsp_product[i], last_prod[i]);
            check(i, "hold_id", 64'(rsp_id[i]), 64'(last_id[i]));
        end else if (ev) begin
            e = (i == 0) ? exp_q0[0] : exp_q1[0];
            check(i, "rsp_id", 64'(rsp_id[i]), 64'(e[64]));
            check(i, "rsp_product", rsp_product[i], e[63:0]);
            hs = rsp_ready[i];
            if (hs) begin
                if (i == 0) void'(exp_q0.pop_front()); else void'(exp_q1.pop_front());
                last_prod[i] = e[63:0];
                last_id[i]   = e[64];
            end
        end
        win = (req0_valid[i] && req1_valid[i]) ? !m_last[i] : req1_valid[i];
        er0 = m_free[i] && req0_valid[i] && !win;
        er1 = m_free[i] && req1_valid[i] && win;
        check(i, "req0_ready", 64'(req0_ready[i]), 64'(er0));
        check(i, "req1_ready", 64'(req1_ready[i]), 64'(er1));
        if (er0 || er1) begin
            e = {win, win ? mul64(req1_a[i], req1_b[i]) : mul64(req0_a[i], req0_b[i])};
            if (i == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
            acc_cyc[i] = cyc;
            m_last[i]  = win;
            m_free[i]  = 1'b0;
        end
        if (hs) m_free[i] = 1'b1;
    endtask

    // Monitor: owns the model and all counters.
    initial begin
        logic done;
        done = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_free[i] = 1'b1; m_last[i] = 1'b1; acc_cyc[i] = 0;
            last_prod[i] = '0; last_id[i] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) mon_step(i);
            if (end_req && !done) begin
                check(0, "queue_empty", 64'(exp_q0.size()), 64'd0);
                check(1, "queue_empty", 64'(exp_q1.size()), 64'd0);
                check(0, "wait_bound", 64'(timeout_cnt), 64'd0);
                done = 1'b1;
            end
        end
    end

    // Consumer: always ready, random, or held off.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                case (rr_mode[i])
                    0:       rsp_ready[i] = 1'b1;
                    1:       rsp_ready[i] = 1'($urandom_range(0, 1));
                    default: rsp_ready[i] = 1'b0;
                endcase
            end
        end
    end

    // ---------------- driver tasks (called at posedge + 1) ----------------
    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic issue(input int i, input int k, input logic [31:0] a, input logic [31:0] b);
        int   n;
        logic got;
        n   = 0;
        got = 1'b0;
        if (k == 0) begin
            req0_a[i] = a; req0_b[i] = b; req0_valid[i] = 1'b1;
        end else begin
            req1_a[i] = a; req1_b[i] = b; req1_valid[i] = 1'b1;
        end
        while (!got && n < 200) begin
            @(negedge clk);
            got = (k == 0) ? req0_ready[i] : req1_ready[i];
            n++;
        end
        if (!got) begin
            timeout_cnt++;
            $display("FAIL accept_wait (inst %0d req %0d): no ready within %0d cycles", i, k, n);
        end
        @(posedge clk);
        #1;
        if (k == 0) req0_valid[i] = 1'b0; else req1_valid[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy[i] && n < 200);
        if (busy[i]) begin
            timeout_cnt++;
            $display("FAIL idle_wait (inst %0d): still busy after %0d cycles", i, n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_suite(input int i);
        int n;
        // single request
        do_reset();
        issue(i, 0, 32'd15, 32'd16);
        wait_idle(i);
        // tie right after reset: req0 first
        do_reset();
        fork
            issue(i, 0, -32'sd32, -32'sd5);
            issue(i, 1, -32'sd5, 32'd47);
        join
        wait_idle(i);
        // corner operands
        for (int j = 0; j < 5; j++) begin
            issue(i, j % 2, ca[j], cb[j]);
            wait_idle(i);
        end
        // backpressure with a requester that gives up before being served
        rr_mode[i] = 2;
        issue(i, 0, 32'd123, -32'sd456);
        req1_a[i] = 32'd77; req1_b[i] = 32'd88; req1_valid[i] = 1'b1;
        n = 0;
        while (!rsp_valid[i] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid[i]) begin
            timeout_cnt++;
            $display("FAIL rsp_wait (inst %0d): no rsp_valid", i);
        end
        repeat (5) @(posedge clk);
        #1;
        req1_valid[i] = 1'b0;
        rr_mode[i] = 0;
        wait_idle(i);
        // reset during EXEC, then a tie must favour req0
        issue(i, 1, 32'd7, 32'd9);
        do_reset();
        fork
            issue(i, 0, 32'd3, 32'd3);
            issue(i, 1, 32'd4, 32'd4);
        join
        wait_idle(i);
        // both requesters continuously valid
        do_reset();
        fork
            begin repeat (2) issue(i, 0, rnd_op(), rnd_op()); end
            begin repeat (2) issue(i, 1, rnd_op(), rnd_op()); end
        join
        wait_idle(i);
        // random traffic with random response backpressure
        rr_mode[i] = 1;
        fork
            begin
                repeat (25) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    issue(i, 0, rnd_op(), rnd_op());
                end
            end
            begin
                repeat (25) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    issue(i, 1, rnd_op(), rnd_op());
                end
            end
        join
        rr_mode[i] = 0;
        wait_idle(i);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req0_valid[i] = 1'b0; req0_a[i] = '0; req0_b[i] = '0;
            req1_valid[i] = 1'b0; req1_a[i] = '0; req1_b[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) run_suite(i);
        repeat (3) @(posedge clk);
        end_req = 1'b1;
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
